// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle for hazard_controller: register tags and enables in,
// forwarding selects, stall/flush controls, watchdog flag and event counters out.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, ResultSrcE, PCSrcE;
  // Data-memory handshake: the M-stage access is valid while MemAccessM is high and
  // completes in the cycle dmem_ready is high; until then the pipeline is held.
  logic             MemAccessM, dmem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] lu_stall_cnt, br_flush_cnt, mem_wait_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, dmem_ready,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, mem_timeout,
    input  lu_stall_cnt, br_flush_cnt, mem_wait_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, dmem_ready,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, mem_timeout,
    output lu_stall_cnt, br_flush_cnt, mem_wait_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard and stall sequencer for the five-stage core: forwarding, load-use interlock,
// branch flush, data-memory wait freeze with watchdog, and saturating event counters.
module hazard_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_controller_if.slave   bus,
  output logic [1:0]           dbg_state
);
  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic              timeout_q, timeout_nx;
  logic [CNT_W-1:0]  lu_cnt, br_cnt, mw_cnt;

  logic mem_stall, lw_stall, br_win, lu_win;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (bus.RegWriteM && bus.RdM != 5'd0 && bus.RdM == rs)
      return 2'b10;
    else if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == rs)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign bus.ForwardAE = fwd_sel(bus.Rs1E);
  assign bus.ForwardBE = fwd_sel(bus.Rs2E);

  assign mem_stall = (state != ERROR) && bus.MemAccessM && !bus.dmem_ready;
  assign lw_stall  = bus.ResultSrcE && bus.RdE != 5'd0 &&
                     (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
  assign br_win    = (state != ERROR) && !mem_stall && bus.PCSrcE;
  assign lu_win    = (state != ERROR) && !mem_stall && !bus.PCSrcE && lw_stall;

  // Stall/flush priority: error, memory wait, taken branch, load-use.
  always_comb begin
    bus.StallF = 1'b0;
    bus.StallD = 1'b0;
    bus.StallE = 1'b0;
    bus.StallM = 1'b0;
    bus.FlushD = 1'b0;
    bus.FlushE = 1'b0;
    bus.FlushW = 1'b0;
    if (state == ERROR || mem_stall) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.StallE = 1'b1;
      bus.StallM = 1'b1;
      bus.FlushW = 1'b1;
    end else if (bus.PCSrcE) begin
      bus.FlushD = 1'b1;
      bus.FlushE = 1'b1;
    end else if (lw_stall) begin
      bus.StallF = 1'b1;
      bus.StallD = 1'b1;
      bus.FlushE = 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    timeout_nx  = timeout_q;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nx    = MEM_WAIT;
          wait_cnt_nx = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!bus.MemAccessM || bus.dmem_ready) begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_nx   = ERROR;
          timeout_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_W'(1);
        end
      end
      ERROR: state_nx = ERROR;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      timeout_q <= timeout_nx;
    end
  end

  // Counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt <= '0;
      br_cnt <= '0;
      mw_cnt <= '0;
    end else begin
      if (lu_win && lu_cnt != '1)    lu_cnt <= lu_cnt + 1'b1;
      if (br_win && br_cnt != '1)    br_cnt <= br_cnt + 1'b1;
      if (mem_stall && mw_cnt != '1) mw_cnt <= mw_cnt + 1'b1;
    end
  end

  assign bus.mem_timeout  = timeout_q;
  assign bus.lu_stall_cnt = lu_cnt;
  assign bus.br_flush_cnt = br_cnt;
  assign bus.mem_wait_cnt = mw_cnt;
  assign dbg_state        = state;
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (default and TIMEOUT=4/CNT_W=2) share one
// stimulus stream; directed scenarios then random traffic against a behavioural model.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(16)) bus_a ();
  hazard_controller_if #(.CNT_W(2))  bus_b ();
  logic [1:0] dbg_a, dbg_b;

  hazard_controller #(.TIMEOUT(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a));
  hazard_controller #(.TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b));

  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       rwm, rww, res_src, pcsrc, mem_acc, ready;

  assign bus_a.Rs1D = rs1d;  assign bus_b.Rs1D = rs1d;
  assign bus_a.Rs2D = rs2d;  assign bus_b.Rs2D = rs2d;
  assign bus_a.Rs1E = rs1e;  assign bus_b.Rs1E = rs1e;
  assign bus_a.Rs2E = rs2e;  assign bus_b.Rs2E = rs2e;
  assign bus_a.RdE  = rde;   assign bus_b.RdE  = rde;
  assign bus_a.RdM  = rdm;   assign bus_b.RdM  = rdm;
  assign bus_a.RdW  = rdw;   assign bus_b.RdW  = rdw;
  assign bus_a.RegWriteM  = rwm;     assign bus_b.RegWriteM  = rwm;
  assign bus_a.RegWriteW  = rww;     assign bus_b.RegWriteW  = rww;
  assign bus_a.ResultSrcE = res_src; assign bus_b.ResultSrcE = res_src;
  assign bus_a.PCSrcE     = pcsrc;   assign bus_b.PCSrcE     = pcsrc;
  assign bus_a.MemAccessM = mem_acc; assign bus_b.MemAccessM = mem_acc;
  assign bus_a.dmem_ready = ready;   assign bus_b.dmem_ready = ready;

  // Control vector order: StallF StallD StallE StallM FlushD FlushE FlushW
  logic [6:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.StallF, bus_a.StallD, bus_a.StallE, bus_a.StallM,
                  bus_a.FlushD, bus_a.FlushE, bus_a.FlushW};
  assign ctl_b = {bus_b.StallF, bus_b.StallD, bus_b.StallE, bus_b.StallM,
                  bus_b.FlushD, bus_b.FlushE, bus_b.FlushW};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: per instance, error flag, length of the current not-ready run,
  // and event tallies clipped to the counter ceiling.
  int to_v [2] = '{16, 4};
  int cap  [2] = '{65535, 3};
  int m_err[2], m_run[2], m_lu[2], m_br[2], m_mw[2];

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rwm && rdm != 0 && rdm == rs) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [6:0] exp_ctl(input int k);
    logic mem, lw;
    mem = mem_acc && !ready;
    lw  = res_src && rde != 0 && (rde == rs1d || rde == rs2d);
    if (m_err[k] != 0 || mem) return 7'b1111_001;
    if (pcsrc)                return 7'b0000_110;
    if (lw)                   return 7'b1100_010;
    return 7'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_run[k] = 0; m_lu[k] = 0; m_br[k] = 0; m_mw[k] = 0;
    end
  endtask

  task automatic check_all();
    logic [1:0] es;
    for (int k = 0; k < 2; k++) begin
      es = (m_err[k] != 0) ? 2'd2 : (m_run[k] > 0 ? 2'd1 : 2'd0);
      check(k == 0 ? "fwdA_a" : "fwdA_b", k == 0 ? bus_a.ForwardAE : bus_b.ForwardAE, exp_fwd(rs1e));
      check(k == 0 ? "fwdB_a" : "fwdB_b", k == 0 ? bus_a.ForwardBE : bus_b.ForwardBE, exp_fwd(rs2e));
      check(k == 0 ? "ctl_a" : "ctl_b", k == 0 ? ctl_a : ctl_b, exp_ctl(k));
      check(k == 0 ? "lu_a" : "lu_b", k == 0 ? bus_a.lu_stall_cnt : 32'(bus_b.lu_stall_cnt), m_lu[k]);
      check(k == 0 ? "br_a" : "br_b", k == 0 ? bus_a.br_flush_cnt : 32'(bus_b.br_flush_cnt), m_br[k]);
      check(k == 0 ? "mw_a" : "mw_b", k == 0 ? bus_a.mem_wait_cnt : 32'(bus_b.mem_wait_cnt), m_mw[k]);
      check(k == 0 ? "tmo_a" : "tmo_b", k == 0 ? bus_a.mem_timeout : bus_b.mem_timeout, m_err[k]);
      check(k == 0 ? "st_a" : "st_b", k == 0 ? dbg_a : dbg_b, es);
    end
  endtask

  task automatic model_step();
    logic mem, lw;
    mem = mem_acc && !ready;
    lw  = res_src && rde != 0 && (rde == rs1d || rde == rs2d);
    for (int k = 0; k < 2; k++) begin
      if (m_err[k] == 0) begin
        if (mem) begin
          if (m_mw[k] < cap[k]) m_mw[k]++;
          m_run[k]++;
          if (m_run[k] == to_v[k]) m_err[k] = 1;
        end else begin
          m_run[k] = 0;
          if (pcsrc) begin
            if (m_br[k] < cap[k]) m_br[k]++;
          end else if (lw) begin
            if (m_lu[k] < cap[k]) m_lu[k]++;
          end
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    #1;
    check_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    rwm = 0; rww = 0; res_src = 0; pcsrc = 0; mem_acc = 0; ready = 1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_tmo_b", bus_b.mem_timeout, 0);
    check("rst_st_b", dbg_b, 0);
    check("rst_lu_a", bus_a.lu_stall_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  int burst;

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Forwarding
    rs1e = 5; rdm = 5; rdw = 5; rwm = 1; rww = 1;
    #1 check("fwd_mem", bus_a.ForwardAE, 2'b10);
    tick();
    rwm = 0;
    #1 check("fwd_wb", bus_a.ForwardAE, 2'b01);
    tick();
    rwm = 1; rs1e = 0; rdm = 0; rdw = 0;
    #1 check("fwd_x0", bus_a.ForwardAE, 2'b00);
    tick();

    // Load-use, then the same with RdE = x0
    clear_inputs(); res_src = 1; rde = 7; rs2d = 7;
    #1 check("lu_ctl", {bus_a.StallF, bus_a.StallD, bus_a.FlushE}, 3'b111);
    tick();
    clear_inputs();
    #1 check("lu_once", ctl_a, 0);
    check("lu_cnt1", bus_a.lu_stall_cnt, 1);
    tick();
    res_src = 1; rde = 0; rs2d = 0;
    #1 check("lu_x0", ctl_a, 0);
    tick();

    // Branch beats load-use
    clear_inputs();
    do_reset();
    pcsrc = 1; res_src = 1; rde = 7; rs2d = 7;
    #1 check("br_ctl", ctl_a, 7'b0000_110);
    tick();
    clear_inputs();
    #1 check("br_cnt1", bus_a.br_flush_cnt, 1);
    check("br_lu0", bus_a.lu_stall_cnt, 0);
    tick();

    // Memory wait with a pending branch
    do_reset();
    mem_acc = 1; ready = 0; pcsrc = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mw_ctl", ctl_a, 7'b1111_001);
      tick();
    end
    ready = 1;
    #1 check("mw_rel", ctl_a, 7'b0000_110);
    check("mw_cnt3", bus_a.mem_wait_cnt, 3);
    tick();
    clear_inputs();
    tick();

    // Watchdog on the TIMEOUT=4 instance, then asynchronous reset in ERROR
    do_reset();
    mem_acc = 1; ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("tmo_low", bus_b.mem_timeout, 0);
      tick();
    end
    #1 check("tmo_high", bus_b.mem_timeout, 1);
    tick();
    ready = 1;
    #1 check("err_stall", ctl_b, 7'b1111_001);
    tick();
    do_reset();
    clear_inputs();

    // Saturation on CNT_W=2
    for (int i = 0; i < 6; i++) begin
      res_src = 1; rde = 3; rs1d = 3;
      tick();
      clear_inputs();
      tick();
    end
    #1 check("sat_b", bus_b.lu_stall_cnt, 3);
    check("nosat_a", bus_a.lu_stall_cnt, 6);
    tick();

    // Random traffic
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
      rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
      rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
      rdw  = 5'($urandom_range(0, 3));
      rwm = 1'($urandom_range(0, 1)); rww = 1'($urandom_range(0, 1));
      res_src = ($urandom_range(0, 2) == 0);
      pcsrc   = ($urandom_range(0, 5) == 0);
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 20);
      if (burst > 0) begin
        mem_acc = 1; ready = 0; burst--;
      end else begin
        mem_acc = 1'($urandom_range(0, 1));
        ready   = ($urandom_range(0, 3) != 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the five-stage RISC-V core. It sits beside the decode/control path and generates operand forwarding selects, load-use interlocks and branch flushes. It also freezes the pipeline while the data-memory port is not ready, with a watchdog and per-event saturating performance counters. It is the single owner of every Stall*/Flush* pipeline-register control.

## Interface
- TIMEOUT, 16: maximum consecutive not-ready data-memory cycles before the error trap (≥2).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers in Decode
- Rs1E, Rs2E, RdE  in  5  source/destination registers in Execute
- RdM, RdW  in  5  destination registers in Memory/Writeback
- RegWriteM, RegWriteW  in  1  register-write enables in Memory/Writeback
- ResultSrcE  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MemAccessM  in  1  Memory-stage instruction accesses data memory (load or store)
- dmem_ready  in  1  data memory completes the access this cycle
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = Writeback result, 10 = Memory ALU result
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  clear (bubble) the corresponding pipeline register
- mem_timeout  out  1  sticky watchdog error
- lu_stall_cnt, br_flush_cnt, mem_wait_cnt  out  CNT_W  saturating event counters

## Operation
- Forwarding (pure combinational): ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00. ForwardBE is the same with Rs2E. The Memory stage wins when both match.
- mem_stall = MemAccessM & ~dmem_ready, in states RUN and MEM_WAIT.
- lw_stall = ResultSrcE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Priority, highest first:
  - ERROR: StallF/D/E/M = 1, FlushW = 1, all other flushes 0.
  - mem_stall: StallF/D/E/M = 1, FlushW = 1. PCSrcE and lw_stall are ignored this cycle; Execute stays frozen, so both re-evaluate once the stall releases.
  - PCSrcE: FlushD = FlushE = 1, no stalls. A load-use hazard in the same cycle is discarded.
  - lw_stall: StallF = StallD = 1, FlushE = 1.
  - Otherwise all Stall/Flush outputs are 0.
- FSM (registered, `state`):
  - RUN → MEM_WAIT when mem_stall. wait_cnt ← 1.
  - MEM_WAIT, dmem_ready = 1 → RUN. wait_cnt ← 0.
  - MEM_WAIT, dmem_ready = 0 and wait_cnt == TIMEOUT−1 → ERROR. mem_timeout ← 1.
  - MEM_WAIT, dmem_ready = 0 otherwise: wait_cnt ← wait_cnt + 1.
  - MEM_WAIT with MemAccessM dropped → RUN. This is a defensive case and does not occur with a frozen M stage.
  - ERROR is absorbing until rst.
- Counters:
  - Each counter increments by 1 per cycle in which its event drives the outputs: lw_stall winning, PCSrcE winning, mem_stall.
  - Each counter saturates at 2^CNT_W−1 and never wraps.
  - No counter increments in ERROR.

## Timing
- Forward/Stall/Flush outputs are combinational from the current inputs and registered state, with zero-cycle latency.
- Load-use stall lasts exactly 1 cycle. The next cycle the load is in M, so lw_stall self-clears and ForwardxE = 10 is not used for the load. The load result reaches Execute via 01 one cycle later.
- Memory wait: stalls last for every cycle with dmem_ready = 0 and release in the cycle dmem_ready = 1. Watchdog trip: the ERROR transition occurs on the edge ending the TIMEOUT-th consecutive not-ready cycle, and mem_timeout is high from the following cycle.
- Reset (rst = 0, asynchronous): state = RUN, wait_cnt = 0, mem_timeout = 0, all counters = 0. Combinational outputs keep following their equations during reset. Asserting reset mid-wait or in ERROR returns to RUN immediately.
- wait_cnt width is clog2(TIMEOUT)+1. Counter updates use saturating compare, not overflow.

## Test plan
- Forwarding: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 → ForwardAE = 10. Drop RegWriteM → 01. Set RdM = RdW = Rs1E = 0 → 00.
- Load-use: ResultSrcE = 1, RdE = 7, Rs2D = 7 for one cycle → StallF = StallD = FlushE = 1 for 1 cycle, lu_stall_cnt = 1. Same stimulus with RdE = 0 → no stall.
- Branch vs load-use: PCSrcE = 1 with lw_stall true → FlushD = FlushE = 1, StallF = 0, br_flush_cnt = 1, lu_stall_cnt = 0.
- Memory wait: MemAccessM = 1, dmem_ready low for 3 cycles then high, PCSrcE = 1 throughout → all Stall = 1 and FlushW = 1 for 3 cycles, FlushD/E = 0. On the 4th cycle FlushD = FlushE = 1 and mem_wait_cnt = 3.
- Timeout: TIMEOUT = 4, dmem_ready held low → mem_timeout rises after 4 cycles and stalls persist. Asserting rst low mid-ERROR clears everything asynchronously.
- Saturation: CNT_W = 2, 6 load-use events → lu_stall_cnt stays at 3.
